ped_request_unit: RTL and testbench
===================================

PED_REQUEST_UNIT -- requirements
Module: ped_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive high samples of btn_raw needed to accept a press.
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles to wait for controller acknowledgement before a bt re-pulse.
REQ-003 Parameter COOLDOWN_CYC, default 8: cycles after service during which presses are ignored.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_raw  input  1  raw pedestrian push-button level, may bounce.
REQ-007 A  input  3  controller main light, one-hot: 001 red, 010 yellow, 100 green.
REQ-008 B  input  3  controller crossing light, same encoding; 100 = no pedestrian service.
REQ-009 bt  output  1  request pulse to the controller.
REQ-010 wait_lamp  output  1  "request registered" indicator.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 dont_walk  output  1  pedestrian don't-walk lamp; always the complement of walk.
REQ-013 walk_cnt  output  4  walk cycles elapsed in the current service, saturating.
REQ-014 fault  output  1  sticky illegal-light-code flag.

Function
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, PULSE, WAIT_ACK, SERVED, COOLDOWN; all outputs registered.
REQ-016 IDLE: btn_raw=1 -> DEBOUNCE with debounce counter cleared; else stay.
REQ-017 DEBOUNCE: btn_raw=0 on any cycle -> IDLE; DEBOUNCE_CYC consecutive highs -> PULSE.
REQ-018 PULSE: bt=1 for exactly one cycle, wait_lamp set to 1, ack timer cleared -> WAIT_ACK.
REQ-019 bt SHALL never be high on two consecutive cycles, since a held level stalls the controller.
REQ-020 WAIT_ACK: B != 100 (010 or 001) is acknowledgement -> SERVED.
REQ-021 WAIT_ACK: no acknowledgement after ACK_TIMEOUT cycles -> PULSE (re-pulse), unlimited retries.
REQ-022 If acknowledgement and timeout occur in the same cycle, acknowledgement SHALL win.
REQ-023 SERVED: walk=1 only while A==001 and B==001, and walk_cnt increments each such cycle, saturating at 15.
REQ-024 SERVED: B==100 -> COOLDOWN, with walk=0, wait_lamp=0, walk_cnt holding its last value.
REQ-025 COOLDOWN: count COOLDOWN_CYC cycles, then go to IDLE and clear walk_cnt to 0.
REQ-026 btn_raw SHALL be ignored in PULSE, WAIT_ACK, SERVED and COOLDOWN: no extra request and no queuing.
REQ-027 fault SHALL set on any cycle where A or B is not one-hot, or where A==100 and B!=100.
REQ-028 fault SHALL stay set until rst; the FSM continues operating while fault is set.
REQ-029 Counters SHALL be sized for their parameter and SHALL not wrap; comparisons are unsigned.

Reset
REQ-030 While rst=1, asynchronously: state IDLE, bt=0, wait_lamp=0, walk=0, dont_walk=1, walk_cnt=0, fault=0, all counters 0.
REQ-031 Reset asserted mid-request or mid-service SHALL abandon the request; no bt pulse follows deassertion.
REQ-032 After deassertion, a press SHALL need the full DEBOUNCE_CYC.

Verification
REQ-033 Bounce: btn_raw 1,1,0,1,1,1,1 -> exactly one bt pulse, one cycle after the 4th consecutive high; wait_lamp=1 from that cycle.
REQ-034 Normal service: after bt, drive B=010 then A=001,B=001 for 6 cycles then B=100 -> walk=1 for 6 cycles, walk_cnt=6, then COOLDOWN, then walk_cnt=0.
REQ-035 Timeout: hold B=100 after bt -> second one-cycle bt pulse 15 cycles later; B=010 on the 15th cycle -> no re-pulse.
REQ-036 Ignore: press held through service and cooldown -> only one bt pulse; a fresh debounced press after cooldown -> new pulse.
REQ-037 Fault: A=011 for one cycle, or A=100 with B=001 -> fault=1 and stays 1 until rst; rst -> all outputs at reset values.

Source files
------------

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: debounces the push-button, pulses a request to the traffic
// controller until acknowledged, drives the walk lamps and flags illegal light codes.
module ped_request_unit #(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned ACK_TIMEOUT  = 15,
   parameter int unsigned COOLDOWN_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_raw,
   input  logic [2:0] A,
   input  logic [2:0] B,
   output logic       bt,
   output logic       wait_lamp,
   output logic       walk,
   output logic       dont_walk,
   output logic [3:0] walk_cnt,
   output logic       fault
);

   localparam logic [2:0] LIGHT_RED = 3'b001;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b100;

   localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYC + 1);
   localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned CD_W  = $clog2(COOLDOWN_CYC + 1);

   // The IDLE sample is the first high, so DEBOUNCE needs DEBOUNCE_CYC-1 more.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'((DEBOUNCE_CYC >= 2) ? DEBOUNCE_CYC - 2 : 0);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'((ACK_TIMEOUT  >= 1) ? ACK_TIMEOUT  - 1 : 0);
   localparam logic [CD_W-1:0]  CD_LAST  = CD_W'((COOLDOWN_CYC  >= 1) ? COOLDOWN_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEBOUNCE,
      S_PULSE,
      S_WAIT_ACK,
      S_SERVED,
      S_COOLDOWN
   } state_t;

   state_t            r_state;
   logic [DEB_W-1:0]  r_deb_cnt;
   logic [ACK_W-1:0]  r_ack_cnt;
   logic [CD_W-1:0]   r_cd_cnt;

   logic w_walk_set;
   logic w_illegal;

   function automatic logic is_onehot(input logic [2:0] v);
      return (v == LIGHT_RED) || (v == LIGHT_YEL) || (v == LIGHT_GRN);
   endfunction

   // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      w_walk_set = 1'b0;
      w_illegal  = 1'b0;
      if (r_state == S_SERVED && A == LIGHT_RED && B == LIGHT_RED)
         w_walk_set = 1'b1;
      if (!is_onehot(A) || !is_onehot(B) || (A == LIGHT_GRN && B != LIGHT_GRN))
         w_illegal = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_deb_cnt <= '0;
         r_ack_cnt <= '0;
         r_cd_cnt  <= '0;
         bt        <= 1'b0;
         wait_lamp <= 1'b0;
         walk      <= 1'b0;
         dont_walk <= 1'b1;
         walk_cnt  <= 4'd0;
         fault     <= 1'b0;
      end else begin
         bt        <= 1'b0;
         walk      <= w_walk_set;
         dont_walk <= !w_walk_set;
         fault     <= fault | w_illegal;
         if (w_walk_set && walk_cnt != 4'hF)
            walk_cnt <= walk_cnt + 4'd1;

         case (r_state)
            S_IDLE: begin
               if (btn_raw) begin
                  r_state   <= S_DEBOUNCE;
                  r_deb_cnt <= '0;
               end
            end
            S_DEBOUNCE: begin
               if (!btn_raw) begin
                  r_state <= S_IDLE;
               end else if (r_deb_cnt == DEB_LAST) begin
                  r_state   <= S_PULSE;
                  bt        <= 1'b1;
                  wait_lamp <= 1'b1;
               end else begin
                  r_deb_cnt <= r_deb_cnt + 1'b1;
               end
            end
            S_PULSE: begin
               r_state   <= S_WAIT_ACK;
               r_ack_cnt <= '0;
            end
            S_WAIT_ACK: begin
               // Acknowledgement is checked first so it wins over a coincident timeout.
               if (B != LIGHT_GRN) begin
                  r_state <= S_SERVED;
               end else if (r_ack_cnt == ACK_LAST) begin
                  r_state <= S_PULSE;
                  bt      <= 1'b1;
               end else begin
                  r_ack_cnt <= r_ack_cnt + 1'b1;
               end
            end
            S_SERVED: begin
               if (B == LIGHT_GRN) begin
                  r_state   <= S_COOLDOWN;
                  wait_lamp <= 1'b0;
                  r_cd_cnt  <= '0;
               end
            end
            S_COOLDOWN: begin
               if (r_cd_cnt == CD_LAST) begin
                  r_state  <= S_IDLE;
                  walk_cnt <= 4'd0;
               end else begin
                  r_cd_cnt <= r_cd_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed bench for ped_request_unit: bounce, timeout re-pulse, service, ignore, reset and fault.
module tb_ped_request_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_raw;
   logic [2:0] A;
   logic [2:0] B;
   logic       bt;
   logic       wait_lamp;
   logic       walk;
   logic       dont_walk;
   logic [3:0] walk_cnt;
   logic       fault;

   int n_checks = 0;
   int n_pass   = 0;
   int bt_seen  = 0;
   int bt_double = 0;
   logic prev_bt = 1'b0;
   int base;

   always #5 clk = ~clk;

   ped_request_unit dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .A         (A),
      .B         (B),
      .bt        (bt),
      .wait_lamp (wait_lamp),
      .walk      (walk),
      .dont_walk (dont_walk),
      .walk_cnt  (walk_cnt),
      .fault     (fault)
   );

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
   endtask

   // One clock: outputs are sampled 1 ns after the rising edge; bt pulses are tallied.
   task automatic tick();
      @(posedge clk);
      #1;
      if (bt === 1'b1) bt_seen++;
      if (bt === 1'b1 && prev_bt === 1'b1) bt_double++;
      prev_bt = bt;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bt"},        8'(bt),        8'd0);
      check({tag, "_wait"},      8'(wait_lamp), 8'd0);
      check({tag, "_walk"},      8'(walk),      8'd0);
      check({tag, "_dont_walk"}, 8'(dont_walk), 8'd1);
      check({tag, "_walk_cnt"},  8'(walk_cnt),  8'd0);
      check({tag, "_fault"},     8'(fault),     8'd0);
   endtask

   logic [6:0] bounce_seq;

   initial begin
      rst = 1'b1; btn_raw = 1'b0; A = 3'b100; B = 3'b100;
      tick(); tick();
      check_reset_outputs("reset");
      rst = 1'b0;

      // Bounce: 1,1,0,1,1,1,1 -> single pulse after the 4th consecutive high.
      bounce_seq = 7'b1111011;
      for (int i = 0; i < 7; i++) begin
         btn_raw = bounce_seq[i];
         tick();
      end
      check("bounce_bt",      8'(bt),        8'd1);
      check("bounce_count",   8'(bt_seen),   8'd1);
      check("bounce_wait",    8'(wait_lamp), 8'd1);
      btn_raw = 1'b0;
      tick();
      check("pulse_one_cyc",  8'(bt),        8'd0);
      check("wait_held",      8'(wait_lamp), 8'd1);

      // Timeout: 15 unacknowledged WAIT_ACK cycles, then re-pulse.
      repeat (14) tick();
      check("no_early_repulse", 8'(bt_seen), 8'd1);
      tick();
      check("repulse_bt",     8'(bt),        8'd1);
      tick();
      check("repulse_end",    8'(bt),        8'd0);
      repeat (14) tick();
      A = 3'b001; B = 3'b010;
      tick();
      check("ack_wins_bt",    8'(bt),        8'd0);
      check("ack_wins_count", 8'(bt_seen),   8'd2);

      // Normal service: six walk cycles, then green crossing ends service.
      for (int i = 1; i <= 6; i++) begin
         A = 3'b001; B = 3'b001;
         tick();
         check("svc_walk",      8'(walk),      8'd1);
         check("svc_dont_walk", 8'(dont_walk), 8'd0);
         check("svc_walk_cnt",  8'(walk_cnt),  8'(i));
      end
      B = 3'b100;
      tick();
      check("cool_walk",      8'(walk),      8'd0);
      check("cool_dont_walk", 8'(dont_walk), 8'd1);
      check("cool_wait",      8'(wait_lamp), 8'd0);
      check("cool_walk_cnt",  8'(walk_cnt),  8'd6);
      A = 3'b100;
      repeat (7) tick();
      check("cool_cnt_hold",  8'(walk_cnt),  8'd6);
      tick();
      check("cool_cnt_clear", 8'(walk_cnt),  8'd0);
      check("svc_no_fault",   8'(fault),     8'd0);

      // Ignore: button held through service and cooldown; walk_cnt saturates.
      base = bt_seen;
      btn_raw = 1'b1;
      repeat (4) tick();
      check("ign_first_bt",   8'(bt),        8'd1);
      tick();
      A = 3'b001; B = 3'b010;
      tick();
      A = 3'b001; B = 3'b001;
      repeat (17) tick();
      check("sat_walk_cnt",   8'(walk_cnt),  8'd15);
      check("sat_walk",       8'(walk),      8'd1);
      B = 3'b010;
      tick();
      check("nowalk_yel",     8'(walk),      8'd0);
      check("nowalk_cnt",     8'(walk_cnt),  8'd15);
      A = 3'b100; B = 3'b100;
      tick();
      repeat (8) tick();
      btn_raw = 1'b0;
      repeat (3) tick();
      check("ign_one_pulse",  8'(bt_seen - base), 8'd1);
      check("ign_cnt_clear",  8'(walk_cnt),  8'd0);
      btn_raw = 1'b1;
      repeat (4) tick();
      check("fresh_bt",       8'(bt),        8'd1);
      check("fresh_count",    8'(bt_seen - base), 8'd2);

      // Reset mid-request abandons it asynchronously.
      btn_raw = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("async_wait",     8'(wait_lamp), 8'd0);
      check("async_dont_walk", 8'(dont_walk), 8'd1);
      tick();
      rst = 1'b0;
      base = bt_seen;
      repeat (20) tick();
      check("abandon_no_bt",  8'(bt_seen - base), 8'd0);
      check("abandon_wait",   8'(wait_lamp), 8'd0);

      // Reset mid-debounce: a full debounce is needed afterwards.
      btn_raw = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check("redeb_early",    8'(bt),        8'd0);
      tick();
      check("redeb_bt",       8'(bt),        8'd1);
      btn_raw = 1'b0;
      tick();

      // Fault: non-one-hot main light, sticky until reset.
      check("pre_fault",      8'(fault),     8'd0);
      A = 3'b011;
      tick();
      check("fault_onehot",   8'(fault),     8'd1);
      A = 3'b100;
      repeat (3) tick();
      check("fault_sticky",   8'(fault),     8'd1);
      rst = 1'b1;
      tick();
      check_reset_outputs("fault_rst");
      rst = 1'b0;
      A = 3'b100; B = 3'b001;
      tick();
      check("fault_grn_conf", 8'(fault),     8'd1);
      B = 3'b100;
      tick();
      check("fault_conf_sticky", 8'(fault),  8'd1);

      check("bt_never_double", 8'(bt_double), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
